// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: sequencer for the reaction-time mini-game.
// It latches a pseudo-random 4-bit delay code on start and waits
// BASE_MS + STEP_MS*code ms before lighting GO. It then measures the
// player's reaction in whole ms and ends in DONE (result or timeout), or
// in FOUL if react is pressed before GO.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-high reset
//   start_btn    start request level (synchronised, debounced)
//   react_btn    player reaction level (synchronised, debounced)
//   delay_sel    delay code latched for the current round
//   go_led       high while in GO
//   result_ms    measured reaction in ms, held until the next round starts
//   result_valid one-cycle pulse on entry to DONE
//   false_start  high while in FOUL
//   timeout      high in DONE when the result saturated at MAX_MS
//   state_o      IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4
module reaction_game_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned BASE_MS  = 1000,
  parameter int unsigned STEP_MS  = 125,
  parameter int unsigned MAX_MS   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic [3:0]  delay_sel,
  output logic        go_led,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]   BASE14     = 14'(BASE_MS);
  localparam logic [13:0]   STEP14     = 14'(STEP_MS);
  localparam logic [13:0]   MAX14      = 14'(MAX_MS);

  state_t        state;
  logic [3:0]    lfsr;
  logic [PW-1:0] presc;
  logic [13:0]   ms;
  logic          start_q;
  logic          react_q;
  logic          start_e;
  logic          react_e;
  logic          tick;
  logic [13:0]   target;

  assign start_e = start_btn & ~start_q;
  assign react_e = react_btn & ~react_q;
  assign tick    = (presc == PRESC_LAST);
  assign target  = BASE14 + STEP14 * {10'd0, delay_sel};

  assign go_led  = (state == S_GO);
  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= 4'b0001;
      presc        <= '0;
      ms           <= '0;
      start_q      <= 1'b1;
      react_q      <= 1'b1;
      delay_sel    <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      start_q      <= start_btn;
      react_q      <= react_btn;
      lfsr         <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      result_valid <= 1'b0;

      // Timebase only runs in WAIT/GO; every transition below overrides it
      // with a clear so the first tick lands TICK_DIV cycles after entry.
      if (state == S_WAIT || state == S_GO) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) ms <= ms + 14'd1;
      end

      case (state)
        S_WAIT: begin
          if (react_e) begin
            state       <= S_FOUL;
            false_start <= 1'b1;
            presc       <= '0;
            ms          <= '0;
          end else if (tick && ms == target - 14'd1) begin
            state <= S_GO;
            presc <= '0;
            ms    <= '0;
          end
        end
        S_GO: begin
          // React reports completed ms only, even on a coinciding tick.
          if (react_e) begin
            result_ms    <= ms;
            result_valid <= 1'b1;
            state        <= S_DONE;
            presc        <= '0;
            ms           <= '0;
          end else if (tick && ms == MAX14 - 14'd1) begin
            result_ms    <= MAX14;
            timeout      <= 1'b1;
            result_valid <= 1'b1;
            state        <= S_DONE;
            presc        <= '0;
            ms           <= '0;
          end
        end
        S_IDLE, S_DONE, S_FOUL: begin
          if (start_e) begin
            delay_sel   <= lfsr;
            result_ms   <= '0;
            timeout     <= 1'b0;
            false_start <= 1'b0;
            state       <= S_WAIT;
            presc       <= '0;
            ms          <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl. A cycle-level reference model
// tracks elapsed cycles per state and derives ms and wait lengths
// arithmetically; all outputs are compared every cycle plus directed checks.
module tb_reaction_game_ctrl;

  localparam int T     = 4;
  localparam int BASE  = 1000;
  localparam int STEP  = 125;
  localparam int MAXMS = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b1;
  logic        react_btn = 1'b0;
  logic [3:0]  delay_sel;
  logic        go_led;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_err    = 0;

  reaction_game_ctrl #(
    .TICK_DIV(T),
    .BASE_MS (BASE),
    .STEP_MS (STEP),
    .MAX_MS  (MAXMS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .delay_sel   (delay_sel),
    .go_led      (go_led),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .false_start (false_start),
    .timeout     (timeout),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE = 0, M_WAIT = 1, M_GO = 2, M_DONE = 3, M_FOUL = 4} mstate_t;

  mstate_t    m_state;
  logic [3:0] m_lfsr;
  logic [3:0] m_code;
  logic       m_start_q, m_react_q;
  int         m_elapsed;   // cycles spent in the current state
  int         m_result;
  logic       m_valid, m_timeout;
  logic       m_se, m_re;

  assign m_se = start_btn & ~m_start_q;
  assign m_re = react_btn & ~m_react_q;

  function automatic int wait_cycles(input logic [3:0] code);
    return (BASE + STEP * int'(code)) * T;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state   <= M_IDLE;
      m_lfsr    <= 4'b0001;
      m_code    <= '0;
      m_start_q <= 1'b1;
      m_react_q <= 1'b1;
      m_elapsed <= 0;
      m_result  <= 0;
      m_valid   <= 1'b0;
      m_timeout <= 1'b0;
    end else begin
      m_start_q <= start_btn;
      m_react_q <= react_btn;
      m_lfsr    <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
      m_valid   <= 1'b0;
      m_elapsed <= m_elapsed + 1;
      case (m_state)
        M_WAIT: begin
          if (m_re) begin
            m_state <= M_FOUL; m_elapsed <= 0;
          end else if (m_elapsed + 1 == wait_cycles(m_code)) begin
            m_state <= M_GO; m_elapsed <= 0;
          end
        end
        M_GO: begin
          if (m_re) begin
            m_result <= m_elapsed / T; m_valid <= 1'b1;
            m_state <= M_DONE; m_elapsed <= 0;
          end else if (m_elapsed + 1 == MAXMS * T) begin
            m_result <= MAXMS; m_timeout <= 1'b1; m_valid <= 1'b1;
            m_state <= M_DONE; m_elapsed <= 0;
          end
        end
        default: begin
          if (m_se) begin
            m_code <= m_lfsr; m_result <= 0; m_timeout <= 1'b0;
            m_state <= M_WAIT; m_elapsed <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("state",        int'(state_o),      int'(m_state));
    chk("delay_sel",    int'(delay_sel),    int'(m_code));
    chk("go_led",       int'(go_led),       int'(m_state == M_GO));
    chk("result_ms",    int'(result_ms),    m_result);
    chk("result_valid", int'(result_valid), int'(m_valid));
    chk("false_start",  int'(false_start),  int'(m_state == M_FOUL));
    chk("timeout",      int'(timeout),      int'(m_timeout));
  end

  // ---------------- stimulus helpers ----------------
  task automatic press_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      react_btn = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    react_btn = 1'b0;
    start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_lfsr(input logic [3:0] v);
    for (int b = 0; b < 20 && m_lfsr != v; b++) @(negedge clk);
  endtask

  // Returns cycles from WAIT entry to GO; pokes start once (ignored).
  task automatic wait_go(input int poke, output int n);
    n = 0;
    while (!go_led && n < 12000) begin
      start_btn = (n == poke);
      @(negedge clk);
      n++;
    end
    start_btn = 1'b0;
    if (!go_led) chk("go_wait_bound", n, -1);
  endtask

  task automatic go_react(input int k, input int poke);
    for (int i = 0; i < k; i++) begin
      start_btn = (i == poke);
      @(negedge clk);
    end
    start_btn = 1'b0;
    react_btn = 1'b1;
    @(negedge clk);
    chk("react_valid",   int'(result_valid), 1);
    chk("react_result",  int'(result_ms),    k / T);
    chk("react_state",   int'(state_o),      3);
    chk("react_go_low",  int'(go_led),       0);
    chk("react_no_tmo",  int'(timeout),      0);
    react_btn = 1'b0;
    @(negedge clk);
    chk("valid_pulse",   int'(result_valid), 0);
  endtask

  task automatic go_timeout();
    for (int i = 0; i < MAXMS * T; i++) @(negedge clk);
    chk("tmo_valid",  int'(result_valid), 1);
    chk("tmo_result", int'(result_ms),    MAXMS);
    chk("tmo_flag",   int'(timeout),      1);
    chk("tmo_state",  int'(state_o),      3);
    @(negedge clk);
    chk("tmo_pulse",  int'(result_valid), 0);
  endtask

  task automatic foul(input int w);
    repeat (w) @(negedge clk);
    react_btn = 1'b1;
    @(negedge clk);
    chk("foul_state", int'(state_o),     4);
    chk("foul_flag",  int'(false_start), 1);
    react_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("foul_go_low", int'(go_led),     0);
    chk("foul_hold",   int'(state_o),    4);
  endtask

  task automatic start_round();
    press_start();
    chk("wait_entry",    int'(state_o),     1);
    chk("entry_no_foul", int'(false_start), 0);
  endtask

  initial begin
    int n;
    int mode;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_idle", int'(state_o), 0);
    start_btn = 1'b0;
    @(negedge clk);

    // Round at LFSR=1: wait length (1000+125)*4 cycles, react 3 ticks + 2 cycles.
    wait_lfsr(4'd1);
    start_round();
    chk("code_at_press", int'(delay_sel), 1);
    wait_go(200, n);
    chk("go_latency_code1", n, 4500);
    go_react(14, 2);

    gap(5);
    start_round();
    foul(int'($urandom_range(0, 3000)));

    gap(3);
    start_round();
    wait_go(-1, n);
    chk("go_latency", n, wait_cycles(m_code));
    go_timeout();

    gap(2);
    start_round();
    wait_go(-1, n);
    go_react(23, -1);   // react coincides with the tick at ms=5

    // Asynchronous reset in the middle of GO.
    gap(4);
    start_round();
    wait_go(-1, n);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state",  int'(state_o),      0);
    chk("arst_go",     int'(go_led),       0);
    chk("arst_code",   int'(delay_sel),    0);
    chk("arst_valid",  int'(result_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      gap(int'($urandom_range(1, 20)));
      start_round();
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        foul(int'($urandom_range(0, 3000)));
      end else begin
        wait_go(int'($urandom_range(0, 3000)), n);
        chk("go_latency_rand", n, wait_cycles(m_code));
        if (mode == 1) go_react(int'($urandom_range(0, MAXMS * T - 1)), int'($urandom_range(0, 10)));
        else go_timeout();
      end
    end
    gap(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
